// File: rtl/axis_arb_pkg.sv
// Shared types, default widths and a width helper for the AXI-Stream
// round-robin packet arbiter.
package axis_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_e;

    localparam int DEF_T_DATA_W  = 8;
    localparam int DEF_NUM_SRC   = 4;
    localparam int DEF_ID_W      = 2;
    localparam int DEF_MAX_BEATS = 256;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/axis_rr_pick.sv
// Rotating-priority encoder: the first requester after last_gnt_i (wrapping)
// wins, so the most recent winner always has the lowest priority.
module axis_rr_pick
    import axis_arb_pkg::*;
#(
    parameter int NUM_SRC = DEF_NUM_SRC,
    parameter int ID_W    = DEF_ID_W
) (
    input  logic [NUM_SRC-1:0] req_i,
    input  logic [ID_W-1:0]    last_gnt_i,
    output logic [ID_W-1:0]    gnt_o,
    output logic               any_req_o
);

    int   cand;
    logic found;

    always_comb begin
        gnt_o     = '0;
        any_req_o = |req_i;
        found     = 1'b0;
        cand      = 0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand = int'(last_gnt_i) + k;
            if (cand >= NUM_SRC) begin
                cand = cand - NUM_SRC;
            end
            if (!found && req_i[cand]) begin
                gnt_o = ID_W'(cand);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-level round-robin arbiter sharing one AXI-Stream sink among NUM_SRC
// masters; the grant is held until TLAST, and runaway packets are cut.
module axis_rr_arbiter
    import axis_arb_pkg::*;
#(
    parameter int t_data_w  = DEF_T_DATA_W,
    parameter int NUM_SRC   = DEF_NUM_SRC,
    parameter int ID_W      = DEF_ID_W,
    parameter int MAX_BEATS = DEF_MAX_BEATS
) (
    input  logic                          ACLK,
    input  logic                          ARESETn,
    input  logic [NUM_SRC*8*t_data_w-1:0] S_TDATA,
    input  logic [NUM_SRC*t_data_w-1:0]   S_TKEEP,
    input  logic [NUM_SRC-1:0]            S_TLAST,
    input  logic [NUM_SRC-1:0]            S_TVALID,
    output logic [NUM_SRC-1:0]            S_TREADY,
    output logic [8*t_data_w-1:0]         M_TDATA,
    output logic [t_data_w-1:0]           M_TKEEP,
    output logic                          M_TLAST,
    output logic                          M_TVALID,
    input  logic                          M_TREADY,
    output logic [ID_W-1:0]               M_TID,
    output logic                          busy,
    output logic                          trunc_err
);

    localparam int DW = 8 * t_data_w;
    localparam int CW = clog2(MAX_BEATS) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BEATS - 1);

    state_e          state_q, state_d;
    logic [ID_W-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0] last_gnt_q, last_gnt_d;
    logic [CW-1:0]   beat_cnt_q, beat_cnt_d;
    logic            trunc_err_q, trunc_err_d;

    logic [ID_W-1:0] pick_gnt;
    logic            any_req;
    logic            src_last;
    logic            cap_hit;
    logic            hs;

    axis_rr_pick #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_pick (
        .req_i      (S_TVALID),
        .last_gnt_i (last_gnt_q),
        .gnt_o      (pick_gnt),
        .any_req_o  (any_req)
    );

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            last_gnt_q  <= ID_W'(NUM_SRC - 1);
            beat_cnt_q  <= '0;
            trunc_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            last_gnt_q  <= last_gnt_d;
            beat_cnt_q  <= beat_cnt_d;
            trunc_err_q <= trunc_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_gnt_d  = last_gnt_q;
        beat_cnt_d  = beat_cnt_q;
        trunc_err_d = 1'b0;
        M_TDATA     = '0;
        M_TKEEP     = '0;
        M_TLAST     = 1'b0;
        M_TVALID    = 1'b0;
        M_TID       = '0;
        S_TREADY    = '0;
        src_last    = S_TLAST[gnt_q];
        cap_hit     = (beat_cnt_q == LAST_CNT);
        hs          = 1'b0;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    gnt_d   = pick_gnt;
                    state_d = XFER;
                end
            end
            XFER: begin
                M_TDATA         = S_TDATA[gnt_q*DW +: DW];
                M_TKEEP         = S_TKEEP[gnt_q*t_data_w +: t_data_w];
                M_TLAST         = src_last | cap_hit;
                M_TVALID        = S_TVALID[gnt_q];
                M_TID           = gnt_q;
                S_TREADY[gnt_q] = M_TREADY;
                hs              = M_TVALID & M_TREADY;
                if (hs) begin
                    beat_cnt_d = beat_cnt_q + CW'(1);
                    // Forced end: the source's remaining beats re-arbitrate as a new packet.
                    if (M_TLAST) begin
                        last_gnt_d  = gnt_q;
                        beat_cnt_d  = '0;
                        state_d     = IDLE;
                        trunc_err_d = ~src_last;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q == XFER);
    assign trunc_err = trunc_err_q;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Self-checking bench for axis_rr_arbiter: per-cycle reference model plus
// packet-level checks of grant order, timing, backpressure and truncation.
module tb_axis_rr_arbiter;

    localparam int TDW  = 2;
    localparam int N    = 4;
    localparam int IDW  = 2;
    localparam int MAXB = 4;
    localparam int DW   = 8 * TDW;

    typedef struct packed {
        logic [DW-1:0]  d;
        logic [TDW-1:0] k;
        logic           l;
    } beat_t;

    typedef struct packed {
        int             cyc;
        logic [IDW-1:0] id;
        logic [DW-1:0]  d;
        logic           l;
    } hs_t;

    typedef struct {
        int       prior;
        logic [3:0] mask;
        int       exp_id;
    } arb_vec_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [N*DW-1:0]    S_TDATA = '0;
    logic [N*TDW-1:0]   S_TKEEP = '0;
    logic [N-1:0]       S_TLAST = '0;
    logic [N-1:0]       S_TVALID = '0;
    logic [N-1:0]       S_TREADY;
    logic [DW-1:0]      M_TDATA;
    logic [TDW-1:0]     M_TKEEP;
    logic               M_TLAST;
    logic               M_TVALID;
    logic               M_TREADY = 1'b1;
    logic [IDW-1:0]     M_TID;
    logic               busy;
    logic               trunc_err;

    axis_rr_arbiter #(
        .t_data_w  (TDW),
        .NUM_SRC   (N),
        .ID_W      (IDW),
        .MAX_BEATS (MAXB)
    ) dut (
        .ACLK      (clk),
        .ARESETn   (rst_n),
        .S_TDATA   (S_TDATA),
        .S_TKEEP   (S_TKEEP),
        .S_TLAST   (S_TLAST),
        .S_TVALID  (S_TVALID),
        .S_TREADY  (S_TREADY),
        .M_TDATA   (M_TDATA),
        .M_TKEEP   (M_TKEEP),
        .M_TLAST   (M_TLAST),
        .M_TVALID  (M_TVALID),
        .M_TREADY  (M_TREADY),
        .M_TID     (M_TID),
        .busy      (busy),
        .trunc_err (trunc_err)
    );

    always #5 clk = ~clk;

    int    n_chk = 0;
    int    n_fail = 0;
    int    cyc = 0;
    beat_t srcq[N][$];
    hs_t   hlog[$];
    logic  rdy_pat[$];
    bit    vgate = 0;
    bit    rdy_rand = 0;
    int    trunc_cnt = 0;
    // Reference: owner is -1 when no packet is in flight.
    int    m_owner = -1;
    int    m_cnt = 0;
    int    m_last = N - 1;
    bit    m_trunc = 0;
    int    pk_id[$], pk_len[$], pk_fc[$], pk_lc[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: bound expired (cycle %0d)", nm, cyc);
    endtask

    task automatic push_beat(input int s, input logic [DW-1:0] d, input logic [TDW-1:0] k, input logic l);
        beat_t b;
        b.d = d;
        b.k = k;
        b.l = l;
        srcq[s].push_back(b);
    endtask

    task automatic push_pkt(input int s, input int len, input logic [DW-1:0] base);
        for (int b = 0; b < len; b++) begin
            push_beat(s, base + DW'(b), '1, b == len - 1);
        end
    endtask

    task automatic drive();
        beat_t b;
        for (int i = 0; i < N; i++) begin
            if (srcq[i].size() > 0) begin
                b = srcq[i][0];
                S_TDATA[i*DW +: DW]   = b.d;
                S_TKEEP[i*TDW +: TDW] = b.k;
                S_TLAST[i]            = b.l;
                S_TVALID[i]           = vgate ? ($urandom_range(0, 3) != 0) : 1'b1;
            end else begin
                S_TDATA[i*DW +: DW]   = '0;
                S_TKEEP[i*TDW +: TDW] = '0;
                S_TLAST[i]            = 1'b0;
                S_TVALID[i]           = 1'b0;
            end
        end
        if (m_owner >= 0 && rdy_pat.size() > 0) M_TREADY = rdy_pat.pop_front();
        else if (rdy_rand) M_TREADY = ($urandom_range(0, 2) != 0);
        else M_TREADY = 1'b1;
    endtask

    task automatic check_outputs();
        logic [N-1:0] e_rdy;
        if (m_owner < 0) begin
            chk("idle M_TVALID", M_TVALID, 0);
            chk("idle M_TDATA", M_TDATA, 0);
            chk("idle M_TKEEP", M_TKEEP, 0);
            chk("idle M_TLAST", M_TLAST, 0);
            chk("idle M_TID", M_TID, 0);
            chk("idle S_TREADY", S_TREADY, 0);
            chk("idle busy", busy, 0);
        end else begin
            e_rdy = '0;
            e_rdy[m_owner] = M_TREADY;
            chk("xfer M_TVALID", M_TVALID, S_TVALID[m_owner]);
            chk("xfer M_TDATA", M_TDATA, S_TDATA[m_owner*DW +: DW]);
            chk("xfer M_TKEEP", M_TKEEP, S_TKEEP[m_owner*TDW +: TDW]);
            chk("xfer M_TLAST", M_TLAST, S_TLAST[m_owner] | (m_cnt == MAXB - 1));
            chk("xfer M_TID", M_TID, m_owner);
            chk("xfer S_TREADY", S_TREADY, e_rdy);
            chk("xfer busy", busy, 1);
        end
        chk("trunc_err", trunc_err, m_trunc);
    endtask

    task automatic update();
        bit nxt_trunc;
        bit found;
        int c;
        bit ends;
        if (M_TVALID && M_TREADY) hlog.push_back({cyc, M_TID, M_TDATA, M_TLAST});
        if (trunc_err) trunc_cnt++;
        for (int i = 0; i < N; i++) begin
            if (S_TVALID[i] && S_TREADY[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
        end
        nxt_trunc = 0;
        if (m_owner < 0) begin
            found = 0;
            for (int k = 1; k <= N; k++) begin
                c = (m_last + k) % N;
                if (!found && S_TVALID[c]) begin
                    m_owner = c;
                    m_cnt   = 0;
                    found   = 1;
                end
            end
        end else if (S_TVALID[m_owner] && M_TREADY) begin
            ends = S_TLAST[m_owner] || (m_cnt == MAXB - 1);
            m_cnt++;
            if (ends) begin
                nxt_trunc = !S_TLAST[m_owner];
                m_last    = m_owner;
                m_owner   = -1;
                m_cnt     = 0;
            end
        end
        m_trunc = nxt_trunc;
    endtask

    task automatic step();
        @(negedge clk);
        drive();
        #1;
        check_outputs();
        update();
        cyc++;
    endtask

    function automatic bit pending();
        bit p;
        p = (m_owner >= 0);
        for (int i = 0; i < N; i++) if (srcq[i].size() > 0) p = 1;
        return p;
    endfunction

    task automatic run_until_idle(input int max_cyc);
        int n;
        n = 0;
        while (pending() && n < max_cyc) begin
            step();
            n++;
        end
        if (pending()) fail_now("drain");
        step();
        step();
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) srcq[i].delete();
        hlog.delete();
        rdy_pat.delete();
        vgate     = 0;
        rdy_rand  = 0;
        trunc_cnt = 0;
        m_owner   = -1;
        m_cnt     = 0;
        m_last    = N - 1;
        m_trunc   = 0;
        S_TVALID  = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst M_TVALID", M_TVALID, 0);
        chk("rst M_TDATA", M_TDATA, 0);
        chk("rst M_TLAST", M_TLAST, 0);
        chk("rst M_TID", M_TID, 0);
        chk("rst S_TREADY", S_TREADY, 0);
        chk("rst busy", busy, 0);
        chk("rst trunc_err", trunc_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic analyze();
        pk_id.delete(); pk_len.delete(); pk_fc.delete(); pk_lc.delete();
        for (int i = 0; i < hlog.size(); i++) begin
            if (i == 0 || hlog[i-1].l) begin
                pk_id.push_back(int'(hlog[i].id));
                pk_len.push_back(0);
                pk_fc.push_back(hlog[i].cyc);
                pk_lc.push_back(hlog[i].cyc);
            end
            pk_len[pk_len.size()-1] = pk_len[pk_len.size()-1] + 1;
            pk_lc[pk_lc.size()-1]   = hlog[i].cyc;
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    function automatic logic [DW-1:0] hdat(input int i);
        return (i < hlog.size()) ? hlog[i].d : 'x;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        arb_vec_t vec[8];
        logic [DW-1:0] exp_d[$];
        int c0;
        int n;
        int total_in;
        int exp_ord[8];

        vec[0] = '{0, 4'b1111, 1};
        vec[1] = '{3, 4'b1111, 0};
        vec[2] = '{1, 4'b0011, 0};
        vec[3] = '{2, 4'b1010, 3};
        vec[4] = '{3, 4'b1000, 3};
        vec[5] = '{1, 4'b0110, 2};
        vec[6] = '{2, 4'b0101, 0};
        vec[7] = '{0, 4'b0001, 0};

        do_reset();

        // Single source, 3 beats.
        c0 = cyc;
        push_beat(1, 16'h11, '1, 0);
        push_beat(1, 16'h22, '1, 0);
        push_beat(1, 16'h33, '1, 1);
        run_until_idle(50);
        analyze();
        chk("single pkts", pk_id.size(), 1);
        chk("single tid", qget(pk_id, 0), 1);
        chk("single first cyc", qget(pk_fc, 0), c0 + 1);
        chk("single last cyc", qget(pk_lc, 0), c0 + 3);
        chk("single d0", hdat(0), 16'h11);
        chk("single d1", hdat(1), 16'h22);
        chk("single d2", hdat(2), 16'h33);
        chk("single trunc", trunc_cnt, 0);
        chk("single busy end", busy, 0);

        // Contention: two rounds of 2-beat packets from every source.
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int s = 0; s < N; s++) push_pkt(s, 2, DW'(16'h100 * (r * N + s)));
        run_until_idle(100);
        analyze();
        chk("contend pkts", pk_id.size(), 8);
        for (int i = 0; i < 8; i++) begin
            chk("contend order", qget(pk_id, i), i % N);
            chk("contend contiguous", qget(pk_lc, i) - qget(pk_fc, i), 1);
            if (i > 0) chk("contend bubble", qget(pk_fc, i) - qget(pk_lc, i - 1), 2);
        end

        // Fairness: src0 and src2 keep requesting.
        do_reset();
        for (int p = 0; p < 3; p++) begin
            push_pkt(0, 1 + p % 2, DW'(16'h200 + 16 * p));
            push_pkt(2, 2 - p % 2, DW'(16'h300 + 16 * p));
        end
        run_until_idle(100);
        analyze();
        chk("fair pkts", pk_id.size(), 6);
        for (int i = 0; i < 6; i++) chk("fair order", qget(pk_id, i), (i % 2) * 2);

        // Backpressure during a 4-beat packet.
        do_reset();
        c0 = cyc;
        push_pkt(2, 4, 16'hA1);
        rdy_pat.push_back(1); rdy_pat.push_back(0);
        rdy_pat.push_back(0); rdy_pat.push_back(1);
        run_until_idle(50);
        analyze();
        chk("bp pkts", pk_id.size(), 1);
        chk("bp len", qget(pk_len, 0), 4);
        chk("bp last cyc", qget(pk_lc, 0), c0 + 6);
        for (int i = 0; i < 4; i++) chk("bp data", hdat(i), DW'(16'hA1 + i));
        chk("bp trunc", trunc_cnt, 0);

        // Truncation: 6 beats with TLAST only on the sixth.
        do_reset();
        push_pkt(3, 6, 16'hC0);
        run_until_idle(50);
        analyze();
        chk("trunc pkts", pk_id.size(), 2);
        chk("trunc tid0", qget(pk_id, 0), 3);
        chk("trunc tid1", qget(pk_id, 1), 3);
        chk("trunc len0", qget(pk_len, 0), 4);
        chk("trunc len1", qget(pk_len, 1), 2);
        chk("trunc pulses", trunc_cnt, 1);
        for (int i = 0; i < 6; i++) chk("trunc data", hdat(i), DW'(16'hC0 + i));

        // Reset during beat 2 of src1, after src0 has just won.
        do_reset();
        push_pkt(0, 1, 16'hD0);
        push_pkt(1, 4, 16'hE0);
        n = 0;
        while (hlog.size() < 2 && n < 20) begin
            step();
            n++;
        end
        if (hlog.size() < 2) fail_now("mid-reset setup");
        @(negedge clk);
        drive();
        #1;
        chk("mid valid before rst", M_TVALID, 1);
        chk("mid tid before rst", M_TID, 1);
        rst_n = 1'b0;
        #1;
        chk("mid rst M_TVALID", M_TVALID, 0);
        chk("mid rst S_TREADY", S_TREADY, 0);
        chk("mid rst busy", busy, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        push_pkt(0, 1, 16'hF0);
        push_pkt(1, 1, 16'hF1);
        run_until_idle(30);
        analyze();
        chk("post rst first", qget(pk_id, 0), 0);
        chk("post rst second", qget(pk_id, 1), 1);

        // Table: previous winner then a request mask; first grant checked.
        do_reset();
        for (int v = 0; v < 8; v++) begin
            push_pkt(vec[v].prior, 1, 16'h500);
            run_until_idle(30);
            hlog.delete();
            for (int s = 0; s < N; s++) if (vec[v].mask[s]) push_pkt(s, 1, DW'(16'h600 + s));
            run_until_idle(60);
            analyze();
            chk("table first grant", qget(pk_id, 0), vec[v].exp_id);
        end

        // Randomized traffic, valid gaps, TKEEP patterns and sink stalls.
        do_reset();
        vgate    = 1;
        rdy_rand = 1;
        total_in = 0;
        for (int t = 0; t < 1500; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                int s;
                int len;
                s   = $urandom_range(0, N - 1);
                len = $urandom_range(1, 7);
                if (srcq[s].size() < 12) begin
                    for (int b = 0; b < len; b++)
                        push_beat(s, DW'($urandom), TDW'($urandom_range(0, 3)), b == len - 1);
                    total_in += len;
                end
            end
            step();
        end
        run_until_idle(3000);
        chk("random beats delivered", hlog.size(), total_in);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
